// File: rtl/scan_decoder.sv
// Registered N-to-M line decoder with three-pin enable gating and an auto-scan mode
// that walks the asserted line around all outputs at a prescaled rate.
module scan_decoder #(
   parameter int SEL_W      = 3,
   parameter int NUM_OUT    = 8,
   parameter int DIV        = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [3:1]         Enable,
   input  logic               Mode,
   input  logic [SEL_W-1:0]   DataIn,
   input  logic               Load,
   output logic [NUM_OUT-1:0] Eq,
   output logic [SEL_W-1:0]   Index,
   output logic               Wrap
);

   localparam int                 PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]      PSC_LAST  = PW'(DIV - 1);
   localparam logic [SEL_W-1:0]   IDX_LAST  = SEL_W'(NUM_OUT - 1);
   localparam logic [SEL_W:0]     NUM_OUT_W = (SEL_W + 1)'(NUM_OUT);
   localparam logic [NUM_OUT-1:0] EQ_IDLE   = {NUM_OUT{ACTIVE_LOW}};

   typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     idx_q, idx_d;
   logic [PW-1:0]        psc_q, psc_d, psc_base;
   logic [NUM_OUT-1:0]   eq_q, eq_d;
   logic                 wrap_q, wrap_d;
   logic                 gate, din_ok, hot;

   always_comb begin
      gate     = Enable[1] & Enable[2] & ~Enable[3];
      din_ok   = {1'b0, DataIn} < NUM_OUT_W;
      state_d  = IDLE;
      if (gate) state_d = Mode ? SCAN : DECODE;
      // Coming out of DECODE the scan always starts on a fresh prescaler.
      psc_base = (state_q == DECODE) ? '0 : psc_q;
      idx_d    = idx_q;
      psc_d    = psc_base;
      wrap_d   = 1'b0;
      hot      = 1'b0;
      eq_d     = EQ_IDLE;

      case (state_d)
         DECODE: begin
            psc_d = '0;
            if (din_ok) begin
               idx_d = DataIn;
               hot   = 1'b1;
            end
         end
         SCAN: begin
            hot = 1'b1;
            if (Load) begin
               idx_d = din_ok ? DataIn : '0;
               psc_d = '0;
            end else if (psc_base == PSC_LAST) begin
               psc_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  idx_d = idx_q + SEL_W'(1);
               end
            end else begin
               psc_d = psc_base + PW'(1);
            end
         end
         default: ;
      endcase

      if (hot) begin
         for (int i = 0; i < NUM_OUT; i++)
            eq_d[i] = ACTIVE_LOW ^ (idx_d == SEL_W'(i));
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         psc_q   <= '0;
         eq_q    <= EQ_IDLE;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         psc_q   <= psc_d;
         eq_q    <= eq_d;
         wrap_q  <= wrap_d;
      end
   end

   assign Eq    = eq_q;
   assign Index = idx_q;
   assign Wrap  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: an 8-line active-low and a 5-line active-high instance share
// stimulus; a table, directed corner sequences and random cycles are checked against a model.
module tb_scan_decoder;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic [3:1] en = 3'b011;
   logic       mode = 1'b0;
   logic       load = 1'b0;
   logic [2:0] din = 3'd0;

   logic [7:0] eq8;
   logic [2:0] idx8;
   logic       w8;
   logic [4:0] eq5;
   logic [2:0] idx5;
   logic       w5;

   scan_decoder #(.SEL_W(3), .NUM_OUT(8), .DIV(DIV), .ACTIVE_LOW(1'b1)) dut8 (
      .Clk(clk), .Reset(rst), .Enable(en), .Mode(mode), .DataIn(din), .Load(load),
      .Eq(eq8), .Index(idx8), .Wrap(w8));

   scan_decoder #(.SEL_W(3), .NUM_OUT(5), .DIV(DIV), .ACTIVE_LOW(1'b0)) dut5 (
      .Clk(clk), .Reset(rst), .Enable(en), .Mode(mode), .DataIn(din), .Load(load),
      .Eq(eq5), .Index(idx5), .Wrap(w5));

   int n_chk = 0;
   int n_pass = 0;

   // Reference state per instance: 0 = 8 lines active-low, 1 = 5 lines active-high.
   int         m_idx [2];
   int         m_psc [2];
   logic [7:0] m_eq  [2];
   logic       m_wrap[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] line_of(input int k, input int idx);
      logic [7:0] oh;
      oh = 8'(1) << idx;
      return (k == 0) ? ~oh : oh;
   endfunction

   task automatic model_upd(input int k);
      int n;
      logic [7:0] idle;
      n    = (k == 0) ? 8 : 5;
      idle = (k == 0) ? 8'hFF : 8'h00;
      m_wrap[k] = 1'b0;
      if (rst) begin
         m_idx[k] = 0; m_psc[k] = 0; m_eq[k] = idle;
      end else if (!(en[1] && en[2] && !en[3])) begin
         m_eq[k] = idle;
      end else if (!mode) begin
         m_psc[k] = 0;
         if (int'(din) < n) begin
            m_idx[k] = int'(din);
            m_eq[k]  = line_of(k, m_idx[k]);
         end else begin
            m_eq[k] = idle;
         end
      end else begin
         if (load) begin
            m_idx[k] = (int'(din) < n) ? int'(din) : 0;
            m_psc[k] = 0;
         end else if (m_psc[k] == DIV - 1) begin
            m_psc[k]  = 0;
            m_wrap[k] = (m_idx[k] + 1 == n);
            m_idx[k]  = (m_idx[k] + 1) % n;
         end else begin
            m_psc[k]++;
         end
         m_eq[k] = line_of(k, m_idx[k]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_upd(0);
      model_upd(1);
      #1;
      chk("m_eq8",   eq8,          m_eq[0]);
      chk("m_idx8",  idx8,         m_idx[0]);
      chk("m_wrap8", w8,           m_wrap[0]);
      chk("m_eq5",   {3'b0, eq5},  m_eq[1]);
      chk("m_idx5",  idx5,         m_idx[1]);
      chk("m_wrap5", w5,           m_wrap[1]);
   endtask

   typedef struct {
      logic       rst;
      logic [3:1] en;
      logic [2:0] din;
      logic [7:0] eq;
      logic [2:0] idx;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [7:0] e8;
      logic [4:0] e5;

      tbl[0]  = '{1'b1, 3'b011, 3'd0, 8'hFF, 3'd0};
      tbl[1]  = '{1'b1, 3'b011, 3'd0, 8'hFF, 3'd0};
      tbl[2]  = '{1'b0, 3'b011, 3'd0, 8'hFE, 3'd0};
      tbl[3]  = '{1'b0, 3'b011, 3'd1, 8'hFD, 3'd1};
      tbl[4]  = '{1'b0, 3'b011, 3'd2, 8'hFB, 3'd2};
      tbl[5]  = '{1'b0, 3'b011, 3'd3, 8'hF7, 3'd3};
      tbl[6]  = '{1'b0, 3'b011, 3'd4, 8'hEF, 3'd4};
      tbl[7]  = '{1'b0, 3'b011, 3'd5, 8'hDF, 3'd5};
      tbl[8]  = '{1'b0, 3'b011, 3'd6, 8'hBF, 3'd6};
      tbl[9]  = '{1'b0, 3'b011, 3'd7, 8'h7F, 3'd7};
      tbl[10] = '{1'b0, 3'b001, 3'd2, 8'hFF, 3'd7};
      tbl[11] = '{1'b0, 3'b111, 3'd2, 8'hFF, 3'd7};
      tbl[12] = '{1'b0, 3'b010, 3'd2, 8'hFF, 3'd7};

      // Reset, addressed sweep and gating combinations.
      for (int i = 0; i < 13; i++) begin
         rst = tbl[i].rst; en = tbl[i].en; mode = 1'b0; load = 1'b0; din = tbl[i].din;
         step();
         chk($sformatf("tbl%0d_eq", i),  eq8,  tbl[i].eq);
         chk($sformatf("tbl%0d_idx", i), idx8, tbl[i].idx);
      end

      // Full scan from Index 0: one step per DIV cycles, single-cycle wrap pulse.
      en = 3'b011; mode = 1'b0; din = 3'd0;
      step();
      mode = 1'b1;
      for (int j = 1; j <= 32; j++) begin
         step();
         e8 = ~(8'(1) << ((j / 4) % 8));
         chk("scan_idx",  idx8, (j / 4) % 8);
         chk("scan_wrap", w8,   j == 32);
         chk("scan_eq",   eq8,  e8);
      end

      // Load coinciding with a scheduled step wins and suppresses the step.
      for (int j = 0; j < 3; j++) step();
      load = 1'b1; din = 3'd6;
      step();
      chk("load_idx",  idx8, 6);
      chk("load_wrap", w8,   0);
      load = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("load_hold", idx8, 6);
      end
      step();
      chk("load_next", idx8, 7);

      // Disable mid-scan at Index 3, prescaler 2; resume from the frozen state.
      load = 1'b1; din = 3'd3;
      step();
      load = 1'b0;
      step();
      step();
      chk("frz_pre", idx8, 3);
      en = 3'b010;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("frz_eq",  eq8,  8'hFF);
         chk("frz_idx", idx8, 3);
      end
      en = 3'b011;
      step();
      chk("resume_eq",  eq8,  8'hF7);
      chk("resume_idx", idx8, 3);
      step();
      chk("resume_step", idx8, 4);
      chk("resume_eq2",  eq8,  8'hEF);

      // Five-line active-high instance: scan and wrap.
      load = 1'b1; din = 3'd0;
      step();
      load = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         step();
         e5 = 5'(1) << ((j / 4) % 5);
         chk("s5_idx",  idx5, (j / 4) % 5);
         chk("s5_eq",   eq5,  e5);
         chk("s5_wrap", w5,   j == 20);
      end

      // Out-of-range address: all lines idle and Index holds.
      load = 1'b1; din = 3'd4;
      step();
      chk("s5_top", eq5, 5'b10000);
      load = 1'b0; mode = 1'b0; din = 3'd6;
      step();
      chk("s5_oor_eq",  eq5,  5'b00000);
      chk("s5_oor_idx", idx5, 4);

      // Reset mid-scan overrides Load, Mode and Enable.
      mode = 1'b1; din = 3'd0;
      step();
      step();
      rst = 1'b1; load = 1'b1; din = 3'd3;
      step();
      chk("rst_eq5",  eq5,  5'b00000);
      chk("rst_idx5", idx5, 0);
      chk("rst_eq8",  eq8,  8'hFF);
      chk("rst_idx8", idx8, 0);
      chk("rst_w8",   w8,   0);
      rst = 1'b0; load = 1'b0;

      // Random traffic against the reference model.
      for (int j = 0; j < 400; j++) begin
         rst  = ($urandom_range(0, 39) == 0);
         en   = ($urandom_range(0, 3) != 0) ? 3'b011 : 3'($urandom);
         mode = ($urandom_range(0, 4) != 0);
         load = ($urandom_range(0, 7) == 0);
         din  = 3'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
